// File: rtl/shift_taps_multi.sv
// Multi-line tap buffer: TAPS chained line delays with a runtime line length and a parallel column output.
// Optional: define SHIFT_TAPS_ZERO_FILL_EN to stream from the first sample with unfilled taps masked to zero.
module shift_taps_multi #(
    parameter int WIDTH   = 8,
    parameter int TAPS    = 3,
    parameter int MAX_LEN = 640,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclr,
    input  logic [LW-1:0]         line_len,
    input  logic                  ivalid,
    input  logic [WIDTH-1:0]      shiftin,
    output logic                  ovalid,
    output logic [TAPS*WIDTH-1:0] taps_out,
    output logic                  primed
);

    localparam int CW = $clog2(MAX_LEN);
    localparam int FW = $clog2(TAPS + 1);

    logic [CW-1:0]         col_q, col_d;
    logic [LW-1:0]         len_q, len_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic                  ovalid_q, ovalid_d;
    logic [TAPS*WIDTH-1:0] taps_q, taps_d;

    logic [WIDTH-1:0] mem [TAPS][MAX_LEN];
    logic [WIDTH-1:0] rd  [TAPS];

    logic primed_w;
    logic wrap_w;
    logic wr_en;

    assign primed_w = (fill_q == FW'(TAPS));
    assign wrap_w   = (LW'(col_q) == (len_q - LW'(1)));
    assign wr_en    = ivalid & ~sclr;

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            rd[k] = mem[k][col_q];
        end
    end

    // No reset on the storage so it can map onto block RAM; reads see pre-write contents.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[0][col_q] <= shiftin;
            for (int k = 1; k < TAPS; k++) begin
                mem[k][col_q] <= rd[k-1];
            end
        end
    end

    always_comb begin
        len_d    = len_q;
        col_d    = col_q;
        fill_d   = fill_q;
        ovalid_d = 1'b0;
        taps_d   = taps_q;
        if (sclr) begin
            if ((line_len == '0) || (line_len > LW'(MAX_LEN))) begin
                len_d = LW'(MAX_LEN);
            end else begin
                len_d = line_len;
            end
            col_d  = '0;
            fill_d = '0;
            taps_d = '0;
        end else if (ivalid) begin
            col_d = wrap_w ? '0 : col_q + CW'(1);
            if (wrap_w && !primed_w) begin
                fill_d = fill_q + FW'(1);
            end
`ifdef SHIFT_TAPS_ZERO_FILL_EN
            // Tap k only carries real data once more than k lines have been written.
            for (int k = 0; k < TAPS; k++) begin
                taps_d[k*WIDTH +: WIDTH] = (fill_q > FW'(k)) ? rd[k] : '0;
            end
            ovalid_d = 1'b1;
`else
            for (int k = 0; k < TAPS; k++) begin
                taps_d[k*WIDTH +: WIDTH] = rd[k];
            end
            ovalid_d = primed_w;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_q    <= '0;
            len_q    <= LW'(MAX_LEN);
            fill_q   <= '0;
            ovalid_q <= 1'b0;
            taps_q   <= '0;
        end else begin
            col_q    <= col_d;
            len_q    <= len_d;
            fill_q   <= fill_d;
            ovalid_q <= ovalid_d;
            taps_q   <= taps_d;
        end
    end

    assign ovalid   = ovalid_q;
    assign taps_out = taps_q;
    assign primed   = primed_w;

endmodule

// File: tb/tb_shift_taps_multi.sv
// Self-checking bench for shift_taps_multi: sample-history reference model plus directed and random stimulus.
module tb_shift_taps_multi;

    localparam int WIDTH   = 8;
    localparam int TAPS    = 3;
    localparam int MAX_LEN = 16;
    localparam int LW      = $clog2(MAX_LEN + 1);
`ifdef SHIFT_TAPS_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic                  clock    = 1'b0;
    logic                  reset_n  = 1'b0;
    logic                  sclr     = 1'b0;
    logic [LW-1:0]         line_len = '0;
    logic                  ivalid   = 1'b0;
    logic [WIDTH-1:0]      shiftin  = '0;
    logic                  ovalid;
    logic [TAPS*WIDTH-1:0] taps_out;
    logic                  primed;

    shift_taps_multi #(.WIDTH(WIDTH), .TAPS(TAPS), .MAX_LEN(MAX_LEN)) dut (
        .clock(clock), .reset_n(reset_n), .sclr(sclr), .line_len(line_len),
        .ivalid(ivalid), .shiftin(shiftin), .ovalid(ovalid),
        .taps_out(taps_out), .primed(primed)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference: every accepted sample since the last restart, indexed by arrival order.
    int m_len;
    int hist[$];
    bit m_ov;
    int m_tap[TAPS];
    bit m_known[TAPS];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_restart(int len);
        m_len = len;
        hist.delete();
        m_ov = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            m_tap[k]   = 0;
            m_known[k] = 1'b1;
        end
    endtask

    task automatic model_sample(int d);
        int n;
        n = hist.size();
        m_ov = ZF ? 1'b1 : (n >= TAPS * m_len);
        for (int k = 0; k < TAPS; k++) begin
            if (n >= (k + 1) * m_len) begin
                m_tap[k]   = hist[n - (k + 1) * m_len];
                m_known[k] = 1'b1;
            end else begin
                m_tap[k]   = 0;
                m_known[k] = ZF;
            end
        end
        hist.push_back(d);
    endtask

    task automatic compare();
        chk("ovalid", 32'(ovalid), 32'(m_ov));
        chk("primed", 32'(primed), 32'(hist.size() >= TAPS * m_len));
        for (int k = 0; k < TAPS; k++) begin
            if (m_known[k]) begin
                chk($sformatf("tap%0d", k), 32'(taps_out[k*WIDTH +: WIDTH]), 32'(m_tap[k]));
            end
        end
    endtask

    task automatic step(bit s, int len, bit v, int d);
        sclr     = s;
        line_len = LW'(len);
        ivalid   = v;
        shiftin  = WIDTH'(d);
        @(posedge clock);
        #1;
        if (s) begin
            model_restart((len == 0 || len > MAX_LEN) ? MAX_LEN : len);
        end else if (v) begin
            model_sample(d & 8'hFF);
        end else begin
            m_ov = 1'b0;
        end
        compare();
    endtask

    function automatic int tap(int k);
        return int'(taps_out[k*WIDTH +: WIDTH]);
    endfunction

    initial begin
        int first;

        model_restart(MAX_LEN);
        #12;
        chk("rst_ovalid", 32'(ovalid), 0);
        chk("rst_taps", 32'(taps_out), 0);
        chk("rst_primed", 32'(primed), 0);
        reset_n = 1'b1;

        // Continuous ramp, line length 4
        step(1, 4, 0, 0);
        for (int i = 0; i < 14; i++) begin
            step(0, 4, 1, i);
            if (i == 10) chk("s1_primed_before", 32'(primed), 0);
            if (i == 11) chk("s1_primed_after", 32'(primed), 1);
            if (i == 12) begin
                chk("s1_ovalid", 32'(ovalid), 1);
                chk("s1_tap0", tap(0), 8);
                chk("s1_tap1", tap(1), 4);
                chk("s1_tap2", tap(2), 0);
            end
        end

        // Same ramp with alternating gaps
        step(1, 4, 0, 0);
        for (int i = 0; i < 14; i++) begin
            step(0, 4, 1, i);
            if (i == 12) begin
                chk("s2_tap0", tap(0), 8);
                chk("s2_tap1", tap(1), 4);
                chk("s2_tap2", tap(2), 0);
            end
            step(0, 4, 0, 8'h55);
            if (i == 12) chk("s2_gap_ovalid", 32'(ovalid), 0);
        end

        // Mid-stream restart with line length 2
        step(1, 2, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 2, 1, 100 + i);
            if (i == 6) begin
                chk("s3_ovalid", 32'(ovalid), 1);
                chk("s3_tap0", tap(0), 104);
                chk("s3_tap1", tap(1), 102);
                chk("s3_tap2", tap(2), 100);
            end
        end

        // sclr wins over ivalid; length 0 selects MAX_LEN
        step(1, 0, 1, 8'hAA);
        first = -1;
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 1, i);
            if (ovalid && first < 0) first = i;
            if (i == 48) begin
                chk("s4_tap0", tap(0), 32);
                chk("s4_tap2", tap(2), 0);
            end
        end
        chk("s4_first_ovalid", first, ZF ? 0 : 48);

        // Asynchronous reset between clock edges
        step(1, 4, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 4, 1, 50 + i);
        #3 reset_n = 1'b0;
        #1;
        chk("s5_ovalid", 32'(ovalid), 0);
        chk("s5_taps", 32'(taps_out), 0);
        chk("s5_primed", 32'(primed), 0);
        #2 reset_n = 1'b1;
        model_restart(MAX_LEN);
        step(1, 4, 0, 0);
        first = -1;
        for (int i = 0; i < 14; i++) begin
            step(0, 4, 1, 200 + i);
            if (ovalid && first < 0) first = i;
        end
        chk("s5_reprime", first, ZF ? 0 : 12);

        // Random traffic with occasional restarts and out-of-range lengths
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                step(1, int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            end else begin
                step(0, 0, bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
